// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register.
//   pipe_state_t : occupancy state of pipe_skid_reg (EMPTY / FULL / SKID).
//   STALL_CNT_W  : width of the optional stall counter, which is present
//                  only when PIPE_SKID_STALL_CNT_EN is defined.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/flopenr.sv
// N-bit register with load enable, asynchronous active-high reset and a
// configurable reset value.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : asynchronous active-high reset, loads RESET_VAL
//   en_i   : load enable, q_o <= d_i when high
//   d_i    : next data
//   q_o    : registered data
module flopenr #(
    parameter int             N         = 8,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline register with an integrated skid buffer. Sits between
// two pipeline stages and absorbs one word of back-pressure so that in_ready
// is a pure register decode (no combinational path from out_ready).
//
// Handshake: a word moves across a boundary at a rising clk edge where both
// valid and ready of that boundary are high; valid never drops and data
// never changes on a boundary until that transfer has happened (or a flush).
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset (state EMPTY, data RESET_VAL)
//   flush      : synchronous flush, drops all held words
//   in_valid   : upstream presents in_data
//   in_ready   : block can accept a word this cycle
//   in_data    : upstream payload
//   out_valid  : out_data holds a valid word
//   out_ready  : downstream accepts out_data this cycle
//   out_data   : payload from the main register
//   stall_cnt  : (only with PIPE_SKID_STALL_CNT_EN) saturating count of
//                cycles with out_valid=1 and out_ready=0
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [WIDTH-1:0]       out_data
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;

    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_en;
    logic [WIDTH-1:0] skid_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and data-register controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;

        if (flush) begin
            // Held words are dropped by forgetting them; the data registers
            // keep their contents.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_en = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    unique case ({in_valid, out_ready})
                        2'b11: main_en = 1'b1;
                        2'b01: state_d = EMPTY;
                        2'b10: begin
                            // Downstream stalled while upstream still sent:
                            // park the new word behind the current one.
                            skid_en = 1'b1;
                            state_d = SKID;
                        end
                        default: state_d = FULL;
                    endcase
                end
                SKID: begin
                    if (out_ready) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    flopenr #(
        .N         (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    flopenr #(
        .N         (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    // Handshake outputs are decoded from the state register only.
    assign out_valid = (state_q == FULL) || (state_q == SKID);
    assign in_ready  = (state_q == EMPTY) || (state_q == FULL);
    assign out_data  = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Saturating stall counter; flush deliberately does not clear it.
    // ------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: reset checks, a table of directed
// vectors, a mid-cycle reset, and randomized traffic against a queue model
// (the block behaves as a two-entry FIFO whose ready is "fewer than two held").
module tb_pipe_skid_reg;

    localparam int W = 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int           n_total  = 0;
    int           n_passed = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model step: pre-edge inputs applied to the queue model.
    task automatic model_step(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
        logic in_x;
        logic out_x;
        in_x  = iv && (exp_q.size() < 2);
        out_x = ordy && (exp_q.size() > 0);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (out_x) void'(exp_q.pop_front());
            if (in_x) exp_q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, W'(out_valid), W'(exp_q.size() > 0));
        check({tag, ".in_ready"},  W'(in_ready),  W'(exp_q.size() < 2));
        if (exp_q.size() > 0) check({tag, ".out_data"}, out_data, exp_q[0]);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs applied before an edge, outputs
    // expected after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // streaming 1..4
        vecs[0]  = '{1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
        // stall into skid, then drain A, B, C
        vecs[5]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 32'hA};
        vecs[6]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 32'hA};
        vecs[7]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 32'hA};
        vecs[8]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 32'hA};
        vecs[9]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hB};
        vecs[10] = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hC};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
        // flush in SKID with a coincident input 0xD
        vecs[12] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11};
        vecs[13] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h11};
        vecs[14] = '{1'b1, 1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
        // flush together with an output transfer in FULL
        vecs[16] = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55};
        vecs[17] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic         fl;
        logic         iv;
        logic         ordy;
        logic [W-1:0] d;

        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        #3;
        // reset outputs, no clock edge needed
        check("rst0.out_valid", W'(out_valid), '0);
        check("rst0.in_ready",  W'(in_ready),  W'(1));
        check("rst0.out_data",  out_data,      '0);
        // inputs are ignored while reset is high
        drive(1'b0, 1'b1, 32'hDEAD, 1'b0);
        tick();
        tick();
        check("rst1.out_valid", W'(out_valid), '0);
        drive(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        tick();
        check("rst2.out_valid", W'(out_valid), '0);
        check("rst2.in_ready",  W'(in_ready),  W'(1));

        // directed table
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            tick();
            check($sformatf("vec%0d.out_valid", i), W'(out_valid), W'(vecs[i].ev));
            check($sformatf("vec%0d.in_ready", i),  W'(in_ready),  W'(vecs[i].er));
            if (vecs[i].ev) check($sformatf("vec%0d.out_data", i), out_data, vecs[i].ed);
        end

        // reset asserted mid-cycle while in SKID; both words are lost
        drive(1'b0, 1'b1, 32'h77, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h88, 1'b0);
        tick();
        check("pre_mid_rst.in_ready", W'(in_ready), '0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst.out_valid", W'(out_valid), '0);
        check("mid_rst.in_ready",  W'(in_ready),  W'(1));
        check("mid_rst.out_data",  out_data,      '0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        check("post_mid_rst.out_valid", W'(out_valid), '0);

        // randomized traffic against the queue model
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 5);
            d    = $urandom;
            drive(fl, iv, d, ordy);
            model_step(fl, iv, d, ordy);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

`ifdef PIPE_SKID_STALL_CNT_EN
        // saturating stall counter
        reset = 1'b1;
        #1;
        check("cnt.reset", W'(stall_cnt), '0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h99, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 70000; c++) @(posedge clk);
        #1;
        check("cnt.sat", W'(stall_cnt), W'(16'hFFFF));
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("cnt.flush", W'(stall_cnt), W'(16'hFFFF));
        check("cnt.flush_empty", W'(out_valid), '0);
        reset = 1'b1;
        #1;
        check("cnt.clear", W'(stall_cnt), '0);
        reset = 1'b0;
`endif

        // final report
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, handshaked pipeline register with an integrated skid buffer. It is the successor to the plain enable flop.
- Inserted between pipeline stages, e.g. IF/ID or ID/EX, so that back-pressure (stall) and flush are handled locally.
- Breaks the combinational ready path: in_ready is driven only from state.
- Guarantees full throughput with no data loss or duplication.

Parameters:
- WIDTH, 32, width of the data payload in bits.
- RESET_VAL, '0, value loaded into both data registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload from the main register.

Behaviour:
- Transfer definitions:
  - Input transfer: in_valid && in_ready at a rising edge of clk.
  - Output transfer: out_valid && out_ready at a rising edge of clk.
- Storage:
  - main_q: WIDTH bits; drives out_data directly.
  - skid_q: WIDTH bits.
  - 2-bit state.
- States and output decoding:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=1.
  - SKID: out_valid=1, in_ready=0.
  - in_ready and out_valid are decoded from the state register only, with no combinational path from the input ports.
- Transitions (flush=0):
  - EMPTY, in_valid=1: main_q<=in_data; go to FULL.
  - EMPTY, in_valid=0: stay in EMPTY.
  - FULL, in_valid=1, out_ready=1: main_q<=in_data; stay in FULL. Streaming runs at 1 word/cycle.
  - FULL, in_valid=0, out_ready=1: go to EMPTY.
  - FULL, in_valid=1, out_ready=0: skid_q<=in_data; go to SKID.
  - FULL, in_valid=0, out_ready=0: hold.
  - SKID, out_ready=1: main_q<=skid_q; go to FULL. in_valid is ignored because in_ready=0.
  - SKID, out_ready=0: hold.
- Latency and ordering:
  - Latency is 1 cycle: a word accepted at edge k is visible on out_data after edge k.
  - Words leave in strict FIFO order.
- flush=1 (highest priority after reset):
  - The next state is EMPTY regardless of any other input.
  - A coincident input transfer counts as accepted and is discarded.
  - A coincident output transfer completes normally.
  - Data registers are not cleared.
- reset=1 (asynchronous):
  - State goes to EMPTY immediately; main_q and skid_q load RESET_VAL.
  - Outputs while reset is high: out_valid=0, in_ready=1, out_data=RESET_VAL.
  - All inputs are ignored until the first edge after reset deasserts.
  - Reset mid-SKID loses both held words; this is the required behaviour.
- Data held while out_ready=0:
  - out_data is stable from cycle to cycle.
  - out_valid never drops without an output transfer or a flush.
- The illegal state encoding (2'b11) recovers to EMPTY on the next edge.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- With the macro defined:
  - Adds output port stall_cnt, 16 bits.
  - It is a saturating count of cycles where out_valid=1 && out_ready=0.
  - Cleared by reset only, not by flush.
  - Holds at 16'hFFFF once saturated.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {EMPTY=2'b00, FULL=2'b01, SKID=2'b10}.
  - localparam STALL_CNT_W = 16.
- Sub-module flopenr(N) provides an N-bit enable register with asynchronous active-high reset and a reset value.
  - It is instantiated twice: main_q and skid_q.
  - Its enables and d-muxes are driven by the state logic in pipe_skid_reg.

Test Plan:
1. Reset check: WIDTH=32, reset pulsed mid-cycle, then released -> out_valid=0, in_ready=1, out_data=0 immediately, with no clock edge needed.
2. Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready stays 1 throughout.
3. Stall into skid: stream 0xA, 0xB, drop out_ready for 3 cycles, in_valid held with 0xC -> state SKID, in_ready=0, out_data=0xA stable. Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplicates.
4. Flush in SKID while in_valid=1 with 0xD -> next cycle out_valid=0, in_ready=1, and 0xD never appears at the output.
5. Flush coincident with an output transfer in FULL (out_ready=1) -> the word is consumed once, then EMPTY.
6. With PIPE_SKID_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. A flush leaves it unchanged; reset clears it to 0.
